// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the instruction cache: machine word, cache field
// widths, the per-frame payload struct and the fetch FSM state encoding.
package cpu_types_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned ICACHE_NSETS = 16;
  localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_NSETS);
  localparam int unsigned ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef logic [WORD_W-1:0]       word_t;
  typedef logic [ICACHE_IDX_W-1:0] icache_idx_t;
  typedef logic [ICACHE_TAG_W-1:0] icache_tag_t;

  typedef struct packed {
    logic        valid;
    icache_tag_t tag;
    word_t       data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // Frame index: word-address bits just above the byte offset.
  function automatic icache_idx_t icache_idx(input word_t addr);
    return addr[ICACHE_IDX_W+1:2];
  endfunction

  // Tag: everything above the index.
  function automatic icache_tag_t icache_tag(input word_t addr);
    return addr[WORD_W-1:ICACHE_IDX_W+2];
  endfunction

endpackage

// File: rtl/icache_frames.sv
// Direct-mapped frame store for the instruction cache.
// Ports:
//   CLK, RST        clock, synchronous active-high reset (clears valid bits only)
//   i_rd_idx        combinational read index
//   o_rd_frame      valid/tag/data of the indexed frame
//   i_wr_en         write strobe; frame becomes valid with the given tag/data
//   i_wr_idx/tag/data  write address and payload
module icache_frames
  import cpu_types_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  icache_idx_t   i_rd_idx,
  output icache_frame_t o_rd_frame,
  input  logic          i_wr_en,
  input  icache_idx_t   i_wr_idx,
  input  icache_tag_t   i_wr_tag,
  input  word_t         i_wr_data
);

  logic [ICACHE_NSETS-1:0] r_valid;
  icache_tag_t             r_tag  [ICACHE_NSETS];
  word_t                   r_data [ICACHE_NSETS];

  // Valid bits are the only state that needs a reset value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag/data arrays: plain write port, no reset.
  always_ff @(posedge CLK) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_frame.valid = r_valid[i_rd_idx];
  assign o_rd_frame.tag   = r_tag[i_rd_idx];
  assign o_rd_frame.data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with a single-word refill path.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   imemREN, imemaddr    fetch request and byte address from the datapath
//   ihit, imemload       combinational hit and instruction word (0 on no hit)
//   iREN, iaddr          refill request and word-aligned address to memory
//   iwait, iload         memory busy flag and refill data
//   miss_count           saturating count of completed refills
module icache_direct
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t miss_count
);

  icache_state_t r_state;
  word_t         r_miss_addr;
  word_t         r_miss_count;

  icache_frame_t w_frame;
  logic          w_match;
  logic          w_fill;

  icache_frames u_frames (
    .CLK        (CLK),
    .RST        (RST),
    .i_rd_idx   (icache_idx(imemaddr)),
    .o_rd_frame (w_frame),
    .i_wr_en    (w_fill),
    .i_wr_idx   (icache_idx(r_miss_addr)),
    .i_wr_tag   (icache_tag(r_miss_addr)),
    .i_wr_data  (iload)
  );

  // Lookup result for the current request, independent of state.
  assign w_match = imemREN & w_frame.valid & (w_frame.tag == icache_tag(imemaddr));

  // Refill lands on the first non-busy FETCH cycle; a reset edge abandons it.
  assign w_fill = (r_state == FETCH) & ~iwait & ~RST;

  // Fetch FSM, miss address latch and refill counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_miss_addr  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (imemREN && !w_match) begin
            r_miss_addr <= {imemaddr[WORD_W-1:2], 2'b00};
            r_state     <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            if (r_miss_count != '1) begin
              r_miss_count <= r_miss_count + WORD_W'(1);
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Interface decode; everything is forced quiet while reset is held.
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    if (!RST) begin
      if (r_state == IDLE) begin
        ihit     = w_match;
        imemload = w_match ? w_frame.data : '0;
      end else begin
        iREN  = 1'b1;
        iaddr = r_miss_addr;
      end
    end
  end

  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: stimulus queues expected hits, refills
// and snapshot checks; a negedge monitor pops and compares them.
module tb_icache_direct;
  import cpu_types_pkg::*;

  logic  CLK;
  logic  RST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  word_t miss_count;

  icache_direct dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum int { K_IHIT, K_IREN, K_IADDR, K_CNT, K_VAL, K_TIMEOUT } chk_kind_t;

  typedef struct {
    string name;
    word_t data;
  } hit_exp_t;

  typedef struct {
    string name;
    word_t addr;
    int    cycles;
  } fill_exp_t;

  typedef struct {
    string     name;
    chk_kind_t kind;
    word_t     exp;
    word_t     act;
  } chk_t;

  hit_exp_t  hit_q[$];
  fill_exp_t fill_q[$];
  chk_t      chk_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int run   = 0;
  int wait_cfg = 0;
  int fetch_cyc = 0;
  bit done = 1'b0;

  // Memory contents: one fixed word for 0x40, else a pattern from the address.
  function automatic word_t mem_word(input word_t a);
    if (a == 32'h0000_0040) return 32'h2001_0005;
    return {a[15:0], 16'hC0DE};
  endfunction

  // Memory model: busy for wait_cfg FETCH cycles, then ready; iwait=0 when idle.
  always @(posedge CLK) begin
    #1;
    if (iREN) begin
      iwait = (fetch_cyc < wait_cfg);
      iload = mem_word(iaddr);
      fetch_cyc++;
    end else begin
      iwait = 1'b0;
      iload = 32'hDEAD_BEEF;
      fetch_cyc = 0;
    end
  end

  task automatic cmp(input string nm, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: refills, hits and snapshot checks, sampled mid-cycle.
  always @(negedge CLK) begin
    if (iREN) begin
      run++;
      if (!iwait) begin
        if (fill_q.size() == 0) begin
          cmp("unexpected_fill", iaddr, 32'hFFFF_FFFF);
        end else begin
          fill_exp_t f;
          f = fill_q.pop_front();
          cmp({f.name, "_iaddr"}, iaddr, f.addr);
          cmp({f.name, "_fetch_cycles"}, 32'(run), 32'(f.cycles));
        end
        run = 0;
      end
    end else begin
      run = 0;
    end

    if (ihit === 1'b1) begin
      if (hit_q.size() == 0) begin
        cmp("unexpected_hit", imemload, 32'hFFFF_FFFF);
      end else begin
        hit_exp_t h;
        h = hit_q.pop_front();
        cmp({h.name, "_imemload"}, imemload, h.data);
      end
    end

    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      case (c.kind)
        K_IHIT:  cmp(c.name, {31'b0, ihit}, c.exp);
        K_IREN:  cmp(c.name, {31'b0, iREN}, c.exp);
        K_IADDR: cmp(c.name, iaddr, c.exp);
        K_CNT:   cmp(c.name, miss_count, c.exp);
        K_VAL:   cmp(c.name, c.act, c.exp);
        default: cmp(c.name, 32'hFFFF_FFFF, 32'h0);
      endcase
    end

    if (done) begin
      cmp("pending_hits", 32'(hit_q.size()), 32'h0);
      cmp("pending_fills", 32'(fill_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  task automatic push_chk(input string nm, input chk_kind_t k, input word_t exp, input word_t act);
    chk_t c;
    c.name = nm;
    c.kind = k;
    c.exp  = exp;
    c.act  = act;
    chk_q.push_back(c);
  endtask

  task automatic push_fill(input string nm, input word_t a, input int cyc);
    fill_exp_t f;
    f.name   = nm;
    f.addr   = a;
    f.cycles = cyc;
    fill_q.push_back(f);
  endtask

  task automatic push_hit(input string nm, input word_t d);
    hit_exp_t h;
    h.name = nm;
    h.data = d;
    hit_q.push_back(h);
  endtask

  // Wait (bounded) for the current request to hit; check latency and count.
  task automatic wait_hit(input string nm, input int exp_lat, input word_t exp_cnt);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 64) begin
      @(negedge CLK);
      if (ihit === 1'b1) begin
        got = 1'b1;
      end else begin
        cyc++;
        @(posedge CLK);
        #1;
      end
    end
    if (!got) begin
      push_chk({nm, "_timeout"}, K_TIMEOUT, 32'h0, 32'h0);
    end else begin
      push_chk({nm, "_latency"}, K_VAL, 32'(exp_lat), 32'(cyc));
      push_chk({nm, "_miss_count"}, K_CNT, exp_cnt, 32'h0);
    end
    @(posedge CLK);
    #1;
    imemREN = 1'b0;
  endtask

  task automatic do_fetch(input string nm, input word_t a, input word_t exp_data,
                          input bit miss, input word_t exp_iaddr, input int wcfg,
                          input int exp_fill_cyc, input int exp_lat, input word_t exp_cnt);
    wait_cfg = wcfg;
    if (miss) push_fill(nm, exp_iaddr, exp_fill_cyc);
    push_hit(nm, exp_data);
    @(posedge CLK);
    #1;
    imemREN  = 1'b1;
    imemaddr = a;
    wait_hit(nm, exp_lat, exp_cnt);
  endtask

  initial begin
    RST      = 1'b1;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b0;
    iload    = 32'h0;

    // Reset state, with a request present while reset is held.
    @(posedge CLK);
    #1;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    push_chk("rst_ihit", K_IHIT, 32'h0, 32'h0);
    push_chk("rst_iren", K_IREN, 32'h0, 32'h0);
    push_chk("rst_iaddr", K_IADDR, 32'h0, 32'h0);
    push_chk("rst_miss_count", K_CNT, 32'h0, 32'h0);
    @(posedge CLK);
    #1;
    RST     = 1'b0;
    imemREN = 1'b0;

    // Cold miss: 3 busy cycles + 1 ready cycle, hit on the 6th cycle.
    do_fetch("cold", 32'h0000_0040, 32'h2001_0005, 1'b1, 32'h0000_0040, 3, 4, 5, 32'd1);

    // Hit reuse: same-cycle hit, no refill.
    do_fetch("reuse", 32'h0000_0040, 32'h2001_0005, 1'b0, 32'h0, 0, 0, 0, 32'd1);

    // Conflict on index 0: 0x80 evicts 0x40, then 0x40 misses again.
    do_fetch("conf_80", 32'h0000_0080, 32'h0080_C0DE, 1'b1, 32'h0000_0080, 1, 2, 3, 32'd2);
    do_fetch("conf_40", 32'h0000_0040, 32'h2001_0005, 1'b1, 32'h0000_0040, 0, 1, 2, 32'd3);

    // Redirect mid-miss: 0x100 still fills, then 0x204 misses and fills.
    wait_cfg = 2;
    push_fill("redir_100", 32'h0000_0100, 3);
    push_fill("redir_204", 32'h0000_0204, 3);
    push_hit("redir_204", 32'h0204_C0DE);
    @(posedge CLK);
    #1;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0100;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    imemaddr = 32'h0000_0204;
    wait_hit("redir", 6, 32'd5);
    do_fetch("redir_reuse", 32'h0000_0100, 32'h0100_C0DE, 1'b0, 32'h0, 0, 0, 0, 32'd5);

    // Reset mid-FETCH abandons the refill and clears the count.
    wait_cfg = 10;
    @(posedge CLK);
    #1;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0300;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST     = 1'b1;
    imemREN = 1'b0;
    push_chk("rst_fetch_hold_iren", K_IREN, 32'h0, 32'h0);
    push_chk("rst_fetch_hold_iaddr", K_IADDR, 32'h0, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    push_chk("rst_fetch_after_iren", K_IREN, 32'h0, 32'h0);
    push_chk("rst_fetch_miss_count", K_CNT, 32'h0, 32'h0);
    do_fetch("rst_reread", 32'h0000_0100, 32'h0100_C0DE, 1'b1, 32'h0000_0100, 0, 1, 2, 32'd1);

    // Zero-wait memory with unaligned low address bits.
    do_fetch("zero_wait", 32'h0000_0013, 32'h0010_C0DE, 1'b1, 32'h0000_0010, 0, 1, 2, 32'd2);

    repeat (3) @(posedge CLK);
    done = 1'b1;
  end

  // Hard bound on simulated time.
  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
